// File: rtl/io_bank_fabric.sv
// io_bank_fabric: CPU address decoder with banked IO channels, per-channel
// wait-state insertion, registered read-data select and a sticky error flag.
module io_bank_fabric #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned WS_WIDTH      = 4,
  parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [15:0]                  addr_i,
  input  logic                         we_i,
  input  logic [7:0]                   data_i,
  output logic                         rdy_o,
  output logic                         ram_cs_o,
  output logic                         ram_we_o,
  output logic                         rom_cs_o,
  output logic [NUM_CH-1:0]            ch_cs_o,
  input  logic [NUM_CH*WS_WIDTH-1:0]   ch_ws_i,
  input  logic [7:0]                   ram_data_i,
  input  logic [7:0]                   rom_data_i,
  input  logic [NUM_CH*8-1:0]          ch_data_i,
  output logic [7:0]                   cpu_data_o,
  output logic [15:0]                  bank_o,
  output logic                         rom_en_o,
  output logic                         err_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_RAM, SEL_ROM, SEL_CH, SEL_REG} sel_t;

  state_t              state_q, state_d;
  sel_t                sel_q, sel_d;
  logic [WS_WIDTH-1:0] cnt_q, cnt_d;
  logic                waited_q, waited_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [1:0]          reg_q, reg_d;
  logic                rdy_d, ram_cs_d, ram_we_d, rom_cs_d, rom_en_d, err_d;
  logic [NUM_CH-1:0]   ch_cs_d;
  logic [15:0]         bank_d;

  logic                is_reg, is_io, is_rom_always, is_overlay, ch_ok;
  logic [CH_W-1:0]     ch_idx;
  logic [WS_WIDTH-1:0] ws_c;

  // Address region decode and the wait-state count of the banked channel.
  always_comb begin
    is_reg        = (addr_i[15:2] == 14'd0);
    is_io         = (addr_i[15:8] == 8'hFE);
    is_rom_always = (addr_i[15:8] == 8'hFF);
    is_overlay    = (addr_i >= 16'hE000) && (addr_i <= 16'hFDFF);
    ch_ok         = (32'(bank_o) < NUM_CH);
    ch_idx        = bank_o[CH_W-1:0];
    ws_c          = ch_ws_i[32'(ch_idx)*WS_WIDTH +: WS_WIDTH];
  end

  // Next-state logic: decode on ready cycles, count down stalls in WAIT.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    waited_d = waited_q;
    ch_d     = ch_q;
    reg_d    = reg_q;
    rdy_d    = rdy_o;
    ram_cs_d = ram_cs_o;
    ram_we_d = ram_we_o;
    rom_cs_d = rom_cs_o;
    ch_cs_d  = ch_cs_o;
    bank_d   = bank_o;
    rom_en_d = rom_en_o;
    err_d    = err_o;

    case (state_q)
      ST_RUN: begin
        if (rdy_o) begin
          waited_d = 1'b0;
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
          rom_cs_d = 1'b0;
          ch_cs_d  = '0;
          sel_d    = SEL_NONE;
          if (is_reg) begin
            sel_d = SEL_REG;
            reg_d = addr_i[1:0];
            if (we_i) begin
              case (addr_i[1:0])
                2'd0:    bank_d[7:0]  = data_i;
                2'd1:    bank_d[15:8] = data_i;
                2'd2:    rom_en_d     = ~data_i[0];
                default: if (data_i[0]) err_d = 1'b0;
              endcase
            end
          end else if (is_io) begin
            if (ch_ok) begin
              sel_d = SEL_CH;
              ch_d  = ch_idx;
              for (int unsigned c = 0; c < NUM_CH; c++) begin
                ch_cs_d[c] = (c == 32'(ch_idx));
              end
              // waited blocks a second stall on the address still held after release
              if ((ws_c != '0) && !waited_q) begin
                cnt_d   = ws_c;
                rdy_d   = 1'b0;
                state_d = ST_WAIT;
              end
            end else begin
              err_d = 1'b1;
            end
          end else if (is_rom_always || is_overlay) begin
            if (we_i) begin
              ram_cs_d = 1'b1;
              ram_we_d = 1'b1;
              sel_d    = SEL_RAM;
            end else if (is_rom_always || rom_en_o) begin
              rom_cs_d = 1'b1;
              sel_d    = SEL_ROM;
            end else begin
              ram_cs_d = 1'b1;
              sel_d    = SEL_RAM;
            end
          end else begin
            ram_cs_d = 1'b1;
            ram_we_d = we_i;
            sel_d    = SEL_RAM;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WS_WIDTH'(1)) begin
          cnt_d    = '0;
          rdy_d    = 1'b1;
          waited_d = 1'b1;
          state_d  = ST_RUN;
        end else begin
          cnt_d = cnt_q - WS_WIDTH'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      sel_q    <= SEL_NONE;
      cnt_q    <= '0;
      waited_q <= 1'b0;
      ch_q     <= '0;
      reg_q    <= '0;
      rdy_o    <= 1'b1;
      ram_cs_o <= 1'b0;
      ram_we_o <= 1'b0;
      rom_cs_o <= 1'b0;
      ch_cs_o  <= '0;
      bank_o   <= '0;
      rom_en_o <= 1'b1;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      waited_q <= waited_d;
      ch_q     <= ch_d;
      reg_q    <= reg_d;
      rdy_o    <= rdy_d;
      ram_cs_o <= ram_cs_d;
      ram_we_o <= ram_we_d;
      rom_cs_o <= rom_cs_d;
      ch_cs_o  <= ch_cs_d;
      bank_o   <= bank_d;
      rom_en_o <= rom_en_d;
      err_o    <= err_d;
    end
  end

  // Read-data mux driven by the registered select.
  always_comb begin
    cpu_data_o = UNMAPPED_DATA;
    case (sel_q)
      SEL_RAM: cpu_data_o = ram_data_i;
      SEL_ROM: cpu_data_o = rom_data_i;
      SEL_CH:  cpu_data_o = ch_data_i[32'(ch_q)*8 +: 8];
      SEL_REG: begin
        case (reg_q)
          2'd0:    cpu_data_o = bank_o[7:0];
          2'd1:    cpu_data_o = bank_o[15:8];
          2'd2:    cpu_data_o = {7'b0, ~rom_en_o};
          default: cpu_data_o = {7'b0, err_o};
        endcase
      end
      default: cpu_data_o = UNMAPPED_DATA;
    endcase
  end

endmodule

// File: doc/io_bank_fabric.md
Name: io_bank_fabric

Overview:
- Parametrised successor to the fixed address decoder. Decodes CPU addresses into RAM, ROM, local registers and NUM_CH banked IO channels in the 0xFE00 page.
- Adds three things the fixed decoder lacks: per-channel wait-state insertion on a ready line, a registered read-data mux, and a sticky unmapped-access error flag.
- Sits between the 65C02 core and all memories/peripherals in nano6502_top.

Parameters:
- NUM_CH, 8, number of IO channels; IO bank values 0..NUM_CH-1 are mapped (1..256).
- WS_WIDTH, 4, width of each per-channel wait-state count.
- UNMAPPED_DATA, 8'hFF, read data returned for unmapped accesses.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- addr_i  in  16  CPU address, current cycle.
- we_i  in  1  CPU write enable, aligned with addr_i.
- data_i  in  8  CPU write data, aligned with addr_i.
- rdy_o  out  1  CPU ready; low stalls the CPU and holds addr_i/we_i/data_i stable.
- ram_cs_o  out  1  registered RAM select.
- ram_we_o  out  1  registered RAM write enable.
- rom_cs_o  out  1  registered ROM select.
- ch_cs_o  out  NUM_CH  registered one-hot IO channel select.
- ch_ws_i  in  NUM_CH*WS_WIDTH  wait states per channel; channel c uses bits [c*WS_WIDTH +: WS_WIDTH].
- ram_data_i  in  8  RAM read data.
- rom_data_i  in  8  ROM read data.
- ch_data_i  in  NUM_CH*8  channel read data; channel c uses bits [c*8 +: 8].
- cpu_data_o  out  8  muxed read data to the CPU.
- bank_o  out  16  current IO bank register.
- rom_en_o  out  1  1 = ROM overlay active.
- err_o  out  1  sticky unmapped-access flag.

Behaviour:
- Reset: bank=0, rom_en=1, err=0, all *_cs_o=0, ram_we_o=0, rdy_o=1, wait counter=0, waited flag=0, sel_q=NONE, cpu_data_o=UNMAPPED_DATA.
- Register map, decoded from addr_i:
  - 0x0000: bank[7:0].
  - 0x0001: bank[15:8].
  - 0x0002: bit0 = ROM-out (0 = ROM, 1 = RAM); rom_en = ~bit0. Reads return {7'b0, ~rom_en}.
  - 0x0003: bit0 = err. Writing 1 clears err; writing 0 has no effect.
  - 0x0000–0x0003 never assert ram_cs_o.
  - Register writes take effect at the posedge where we_i=1 and rdy_o=1. A new bank applies from the next access.
- Region decode, in priority order:
  - Regs: 0x0000–0x0003.
  - IO: 0xFE00–0xFEFF. Mapped to channel = bank if bank < NUM_CH, otherwise unmapped.
  - ROM-always: 0xFF00–0xFFFF. Reads go to ROM.
  - Overlay: 0xE000–0xFDFF. Reads go to ROM if rom_en, otherwise RAM.
  - Everything else: RAM.
  - Writes to ROM-always or overlay addresses always go to RAM (ram_cs_o=1, ram_we_o=1, rom_cs_o=0). This is write-through under ROM.
- Selects:
  - Decoded at each posedge where rdy_o=1 and registered into *_cs_o and ram_we_o, so they are valid one cycle after the address.
  - Held unchanged while rdy_o=0.
  - At most one of ram/rom/ch selects is high.
- Unmapped IO access: no select asserted, err<=1, data=UNMAPPED_DATA, no wait.
- Read mux:
  - sel_q is registered alongside the selects.
  - cpu_data_o is combinational from sel_q: ROM, RAM, channel, regs, or UNMAPPED_DATA.
- Wait-state FSM, states RUN and WAIT:
  - RUN: at a posedge with a mapped IO access to channel c, W=ch_ws_i[c] > 0 and waited=0 → cnt<=W, rdy_o<=0, go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt==1 → rdy_o<=1, waited<=1, cnt<=0, go to RUN.
  - waited clears on the next posedge with rdy_o=1. This suppresses retriggering on the held address, so each access stalls exactly W cycles.
  - W=0: no stall.
  - Reads and writes are stalled identically.
- Reset asserted mid-WAIT: immediate return to reset values, rdy_o=1.

Test Plan:
- Reset, then read 0x0000/0x0001/0x0002/0x0003 → 0x00, 0x00, 0x00, 0x00; rom_en_o=1, rdy_o=1.
- Read 0xE123 with rom_en=1 → rom_cs_o next cycle, cpu_data_o=rom_data_i. Write 0x01 to 0x0002, read 0xE123 → ram_cs_o. Write 0x5A to 0xFFFC → ram_we_o=1, rom_cs_o=0.
- Bank=3, ch_ws_i[3]=2, read 0xFE10 → rdy_o low exactly 2 cycles, ch_cs_o=8'b0000_1000 held throughout, cpu_data_o=ch_data_i[3] on release, no second stall.
- Bank=3, ch_ws_i[3]=0, back-to-back reads 0xFE00, 0xFE01 → rdy_o stays 1, ch_cs_o[3] on both.
- Bank=0x0100 (≥ NUM_CH), read 0xFE00 → cpu_data_o=0xFF, err_o=1, no select. Write 0x01 to 0x0003 → err_o=0.
- ch_ws_i[2]=5, assert rst_i on the 3rd stall cycle → next cycle rdy_o=1, bank_o=0, all selects 0.
